// File: rtl/joypad_poller_if.sv
// joypad_poller_if: CPU-facing MMIO word bus for joypad_poller.
// Signals: bus_addr (word select), bus_we / bus_re (single-cycle strobes),
// bus_wdata (write data), bus_rdata (read data, combinational on bus_addr).
// Modports: master drives the bus (decoder side), slave is joypad_poller.
interface joypad_poller_if;
   logic [1:0]  bus_addr;
   logic        bus_we;
   logic        bus_re;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;

   modport master (output bus_addr, bus_we, bus_re, bus_wdata, input bus_rdata);
   modport slave  (input bus_addr, bus_we, bus_re, bus_wdata, output bus_rdata);
endinterface

// File: rtl/joypad_poller.sv
// joypad_poller: periodically starts an nes_bridge transaction, reads back the
// joypad byte, derives press/release edges and exposes them through a small
// MMIO register file (STATUS, BUTTONS, EVENT, CTRL) with a level interrupt.
// Ports:
//   clk, rst         sole clock; synchronous active-high reset
//   bus              joypad_poller_if.slave MMIO word bus
//   irq              level interrupt
//   br_start         one-cycle start pulse to nes_bridge
//   br_addr          nes_bridge rdata_addr
//   br_rdata         nes_bridge rdata (combinational on br_addr)
// Build option: define JOYPAD_EVENT_FIFO_EN to build the event FIFO; without
// it STATUS bit1 is a sticky "changed" flag cleared by reading BUTTONS.
module joypad_poller #(
   parameter int unsigned POLL_CYCLES    = 1_000_000,
   parameter int unsigned TIMEOUT_CYCLES = 4_000_000,
   parameter int unsigned FIFO_DEPTH     = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   joypad_poller_if.slave        bus,
   output logic                  irq,
   output logic                  br_start,
   output logic [1:0]            br_addr,
   input  logic [7:0]            br_rdata
);

   localparam int unsigned PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [2:0] {S_IDLE, S_KICK, S_GAP, S_WAIT, S_CHECK, S_READ} state_t;

   state_t         state_q, state_d;
   logic [PW-1:0]  poll_cnt_q, poll_cnt_d;
   logic [TW-1:0]  to_cnt_q, to_cnt_d;
   logic           br_start_q, br_start_d;
   logic [1:0]     br_addr_q, br_addr_d;
   logic           read_go, to_hit;

   logic           en_q, irq_en_q, valid_q, timeout_q;
   logic [7:0]     buttons_q;
   logic [7:0]     pressed, released;
   logic           ev_push;
   logic           st_bit1, st_bit2;
   logic [31:0]    ev_word;

   logic wr_ctrl, wr_status;
   assign wr_ctrl   = bus.bus_we && (bus.bus_addr == 2'd3);
   assign wr_status = bus.bus_we && (bus.bus_addr == 2'd0);

   // Poll sequencer: next state, counters and bridge-side controls.
   always_comb begin
      state_d    = state_q;
      poll_cnt_d = poll_cnt_q;
      to_cnt_d   = to_cnt_q;
      read_go    = 1'b0;
      to_hit     = 1'b0;
      br_start_d = 1'b0;
      br_addr_d  = 2'b00;
      unique case (state_q)
         S_IDLE: begin
            if (en_q) begin
               if (poll_cnt_q == PW'(POLL_CYCLES - 1)) begin
                  state_d    = S_KICK;
                  poll_cnt_d = '0;
               end else begin
                  poll_cnt_d = poll_cnt_q + PW'(1);
               end
            end
         end
         S_KICK: state_d = S_GAP;
         S_GAP: begin
            to_cnt_d = '0;
            state_d  = S_WAIT;
         end
         S_WAIT: begin
            if (br_rdata[0]) begin
               state_d = S_CHECK;
            end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
               to_hit  = 1'b1;
               state_d = S_IDLE;
            end else begin
               to_cnt_d = to_cnt_q + TW'(1);
            end
         end
         S_CHECK: begin
            if (br_rdata[0]) begin
               state_d = S_READ;
            end else begin
               to_hit  = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_READ: begin
            read_go = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // Bridge controls are registered from the next state so they line up
      // with the state they belong to.
      br_start_d = (state_d == S_KICK);
      if (state_d == S_CHECK) br_addr_d = 2'b01;
      if (state_d == S_READ)  br_addr_d = 2'b10;
   end

   // Sequencer state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         poll_cnt_q <= '0;
         to_cnt_q   <= '0;
         br_start_q <= 1'b0;
         br_addr_q  <= 2'b00;
      end else begin
         state_q    <= state_d;
         poll_cnt_q <= poll_cnt_d;
         to_cnt_q   <= to_cnt_d;
         br_start_q <= br_start_d;
         br_addr_q  <= br_addr_d;
      end
   end

   assign br_start = br_start_q;
   assign br_addr  = br_addr_q;

   // Edge detection against the last good byte; br_rdata is the new byte in S_READ.
   assign pressed  = br_rdata & ~buttons_q;
   assign released = ~br_rdata & buttons_q;
   assign ev_push  = read_go && ((pressed | released) != 8'd0);

   // Control and status registers; a same-cycle set beats a software clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         en_q      <= 1'b0;
         irq_en_q  <= 1'b0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         buttons_q <= 8'd0;
      end else begin
         if (wr_ctrl) begin
            en_q     <= bus.bus_wdata[0];
            irq_en_q <= bus.bus_wdata[1];
         end
         if (read_go) begin
            buttons_q <= br_rdata;
            valid_q   <= 1'b1;
         end
         if (to_hit) timeout_q <= 1'b1;
         else if (wr_status && bus.bus_wdata[3]) timeout_q <= 1'b0;
      end
   end

`ifdef JOYPAD_EVENT_FIFO_EN
   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   logic [15:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          overflow_q;
   logic          rd_event, pop, full, push_ok;

   assign rd_event = bus.bus_re && (bus.bus_addr == 2'd2);
   assign pop      = rd_event && (count_q != '0);
   assign full     = (count_q == CW'(FIFO_DEPTH));
   // A pop in the same cycle frees a slot before the push lands.
   assign push_ok  = ev_push && (!full || pop);

   // FIFO pointers, occupancy and sticky overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
         unique case ({push_ok, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: ;
         endcase
         if (ev_push && !push_ok) overflow_q <= 1'b1;
         else if (wr_status && bus.bus_wdata[2]) overflow_q <= 1'b0;
      end
   end

   // Event storage, {pressed, released} per entry.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= {pressed, released};
   end

   assign st_bit1 = (count_q != '0);
   assign st_bit2 = overflow_q;
   assign ev_word = st_bit1 ? {15'd0, 1'b1, mem_q[rd_ptr_q]} : 32'd0;
`else
   localparam int unsigned UNUSED_DEPTH = FIFO_DEPTH;

   logic changed_q;
   logic rd_buttons;
   logic unused_wdata2;

   assign rd_buttons    = bus.bus_re && (bus.bus_addr == 2'd1);
   assign unused_wdata2 = bus.bus_wdata[2];

   // Sticky change flag; a new change wins over a same-cycle BUTTONS read.
   always_ff @(posedge clk) begin
      if (rst) changed_q <= 1'b0;
      else if (ev_push) changed_q <= 1'b1;
      else if (rd_buttons) changed_q <= 1'b0;
   end

   assign st_bit1 = changed_q;
   assign st_bit2 = 1'b0;
   assign ev_word = 32'd0;
`endif

   // Register read mux.
   always_comb begin
      bus.bus_rdata = 32'd0;
      unique case (bus.bus_addr)
         2'd0:    bus.bus_rdata = {28'd0, timeout_q, st_bit2, st_bit1, valid_q};
         2'd1:    bus.bus_rdata = {24'd0, buttons_q};
         2'd2:    bus.bus_rdata = ev_word;
         default: bus.bus_rdata = {30'd0, irq_en_q, en_q};
      endcase
   end

   assign irq = irq_en_q & st_bit1;

   logic unused_wdata_hi;
   assign unused_wdata_hi = ^bus.bus_wdata[31:4];

endmodule

// File: tb/tb_joypad_poller.sv
// tb_joypad_poller: bench for joypad_poller with a behavioural nes_bridge and
// a transaction-level reference model of the poller.
`timescale 1ns/1ps
module tb_joypad_poller;
   localparam int unsigned P = 16;
   localparam int unsigned T = 32;
   localparam int unsigned D = 8;
`ifdef JOYPAD_EVENT_FIFO_EN
   localparam bit FIFO = 1'b1;
`else
   localparam bit FIFO = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   joypad_poller_if bus_if ();
   logic       irq, br_start;
   logic [1:0] br_addr;
   logic [7:0] br_rdata;

   joypad_poller #(.POLL_CYCLES(P), .TIMEOUT_CYCLES(T), .FIFO_DEPTH(D)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus_if.slave),
      .irq      (irq),
      .br_start (br_start),
      .br_addr  (br_addr),
      .br_rdata (br_rdata)
   );

   int n_checks = 0;
   int n_errors = 0;
   bit chk_on = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Next-transaction configuration shared by the bridge and the model.
   logic [7:0]  cfg_joy   = 8'h00;
   int          cfg_lat   = 3;
   bit          cfg_good  = 1'b1;
   bit          cfg_stuck = 1'b0;

   // Behavioural nes_bridge: ready drops right after start, rises cfg_lat
   // cycles after the start cycle unless stuck.
   logic       b_ready = 1'b1, b_busy = 1'b0, b_good = 1'b0, b_stuck = 1'b0;
   logic [7:0] b_joy = 8'h00;
   int         b_t = 0, b_lat = 2;
   always @(posedge clk) begin
      if (br_start) begin
         b_ready <= 1'b0; b_busy <= 1'b1; b_t <= 1;
         b_lat <= cfg_lat; b_good <= cfg_good; b_stuck <= cfg_stuck; b_joy <= cfg_joy;
      end else if (b_busy) begin
         if (!b_stuck && b_t == b_lat - 1) begin
            b_ready <= 1'b1; b_busy <= 1'b0;
         end
         b_t <= b_t + 1;
      end
   end
   always_comb begin
      case (br_addr)
         2'd0:    br_rdata = {7'd0, b_ready};
         2'd1:    br_rdata = {7'd0, b_good};
         2'd2:    br_rdata = b_joy;
         default: br_rdata = 8'd0;
      endcase
   end

   // Reference model: transactions described by offset from the start cycle.
   bit          m_en, m_irq_en, m_valid, m_to, m_ovf, m_chg;
   logic [7:0]  m_btn;
   logic [15:0] m_q[$];
   bit          m_busy;
   int          m_c, m_t, m_lat;
   bit          m_good, m_stuck;
   logic [7:0]  m_joy;
   int          m_polls = 0, m_tos = 0;
   bit          ev, to_ev;
   logic [7:0]  nb, pr, rl;

   always @(posedge clk) begin
      if (rst) begin
         m_en = 0; m_irq_en = 0; m_valid = 0; m_to = 0; m_ovf = 0; m_chg = 0;
         m_btn = 8'h00; m_q.delete(); m_busy = 0; m_c = 0; m_t = 0;
      end else begin
         ev = 0; to_ev = 0; pr = 8'h00; rl = 8'h00;
         if (!m_busy) begin
            if (m_en) begin
               if (m_c == int'(P) - 1) begin m_busy = 1; m_t = 0; m_c = 0; end
               else m_c++;
            end
         end else begin
            if (m_t == 0) begin
               m_lat = cfg_lat; m_good = cfg_good; m_stuck = cfg_stuck; m_joy = cfg_joy;
            end
            if (m_stuck) begin
               if (m_t == int'(T) + 1) begin to_ev = 1; m_busy = 0; end
               else m_t++;
            end else if (m_t == m_lat + 1 && !m_good) begin
               to_ev = 1; m_busy = 0;
            end else if (m_t == m_lat + 2) begin
               nb = m_joy;
               pr = nb & ~m_btn;
               rl = ~nb & m_btn;
               m_btn = nb; m_valid = 1; ev = ((pr | rl) != 8'h00);
               m_busy = 0; m_polls++;
            end else m_t++;
         end
         if (bus_if.bus_we && bus_if.bus_addr == 2'd0) begin
            if (bus_if.bus_wdata[2]) m_ovf = 0;
            if (bus_if.bus_wdata[3]) m_to = 0;
         end
         if (to_ev) begin m_to = 1; m_tos++; end
         if (bus_if.bus_we && bus_if.bus_addr == 2'd3) begin
            m_en = bus_if.bus_wdata[0]; m_irq_en = bus_if.bus_wdata[1];
         end
`ifdef JOYPAD_EVENT_FIFO_EN
         if (bus_if.bus_re && bus_if.bus_addr == 2'd2 && m_q.size() != 0) void'(m_q.pop_front());
         if (ev) begin
            if (m_q.size() < int'(D)) m_q.push_back({pr, rl});
            else m_ovf = 1;
         end
`else
         if (bus_if.bus_re && bus_if.bus_addr == 2'd1) m_chg = 0;
         if (ev) m_chg = 1;
`endif
      end
   end

   function automatic logic exp_b1();
      return FIFO ? (m_q.size() != 0) : m_chg;
   endfunction

   function automatic logic [31:0] exp_rdata(input logic [1:0] a);
      case (a)
         2'd0:    return {28'd0, m_to, FIFO ? m_ovf : 1'b0, exp_b1(), m_valid};
         2'd1:    return {24'd0, m_btn};
         2'd2:    return (m_q.size() != 0) ? {15'd0, 1'b1, m_q[0]} : 32'd0;
         default: return {30'd0, m_irq_en, m_en};
      endcase
   endfunction

   function automatic logic [1:0] exp_addr();
      if (m_busy && !m_stuck && m_t == m_lat + 1) return 2'b01;
      if (m_busy && !m_stuck && m_t == m_lat + 2) return 2'b10;
      return 2'b00;
   endfunction

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_on) begin
         check("br_start", {31'd0, br_start}, {31'd0, m_busy && m_t == 0});
         check("br_addr", {30'd0, br_addr}, {30'd0, exp_addr()});
         check("irq", {31'd0, irq}, {31'd0, m_irq_en & exp_b1()});
         check("bus_rdata", bus_if.bus_rdata, exp_rdata(bus_if.bus_addr));
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus_if.bus_addr = a; bus_if.bus_wdata = d; bus_if.bus_we = 1'b1;
      tick();
      bus_if.bus_we = 1'b0;
   endtask

   task automatic bus_rd(input logic [1:0] a);
      bus_if.bus_addr = a; bus_if.bus_re = 1'b1;
      tick();
      bus_if.bus_re = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
      bus_if.bus_addr = a; bus_if.bus_re = 1'b1;
      @(negedge clk);
      check(name, bus_if.bus_rdata, exp);
      tick();
      bus_if.bus_re = 1'b0;
   endtask

   task automatic expired(input string name);
      n_checks++; n_errors++;
      $display("FAIL %s: wait bound expired at %0t", name, $time);
   endtask

   // Enable polling until exactly one good poll completes, then disable.
   task automatic run_poll();
      int p0 = m_polls;
      int n = 0;
      wr(2'd3, 32'h3);
      while (m_polls == p0 && n < 200) begin tick(); n++; end
      if (m_polls == p0) expired("poll_wait");
      wr(2'd3, 32'h2);
   endtask

   initial begin
      int n;
      int t0;
      rst = 1'b1;
      bus_if.bus_addr = 2'd0; bus_if.bus_we = 1'b0; bus_if.bus_re = 1'b0; bus_if.bus_wdata = 32'd0;
      tick(); tick();
      chk_on = 1'b1;
      rst = 1'b0;

      // Reset values.
      rd(2'd0, 32'h0, "rst_status");
      rd(2'd1, 32'h0, "rst_buttons");
      rd(2'd2, 32'h0, "rst_event");
      rd(2'd3, 32'h0, "rst_ctrl");

      // First poll reports held buttons as pressed.
      cfg_joy = 8'h81; cfg_lat = 3; cfg_good = 1; cfg_stuck = 0;
      run_poll();
      rd(2'd0, 32'h3, "p1_status");
      rd(2'd1, 32'h81, "p1_buttons");
      rd(2'd2, FIFO ? 32'h0001_8100 : 32'h0, "p1_event");
      rd(2'd2, 32'h0, "p1_event_empty");
      rd(2'd0, 32'h1, "p1_status_after");

      // 0x81 -> 0x03.
      cfg_joy = 8'h03; cfg_lat = 5;
      run_poll();
      rd(2'd0, 32'h3, "p2_status");
      rd(2'd2, FIFO ? 32'h0001_0280 : 32'h0, "p2_event");
      rd(2'd1, 32'h03, "p2_buttons");
      rd(2'd0, 32'h1, "p2_status_after");

      // Identical bytes queue a single event.
      cfg_joy = 8'h55; cfg_lat = 2;
      run_poll();
      rd(2'd2, FIFO ? 32'h0001_5402 : 32'h0, "p3_event");
      rd(2'd1, 32'h55, "p3_buttons");
      run_poll();
      rd(2'd0, 32'h1, "p4_no_change");
      rd(2'd2, 32'h0, "p4_event_empty");

      // Nine changes with no pops.
      for (int i = 1; i <= 9; i++) begin
         cfg_joy = 8'(i);
         run_poll();
      end
      rd(2'd0, FIFO ? 32'h7 : 32'h3, "ovf_status");
      rd(2'd2, FIFO ? 32'h0001_0054 : 32'h0, "ovf_first_event");
      for (int i = 0; i < 7; i++) bus_rd(2'd2);
      rd(2'd2, 32'h0, "ovf_drained");
      rd(2'd0, FIFO ? 32'h5 : 32'h3, "ovf_status_drained");
      wr(2'd0, 32'h4);
      rd(2'd0, FIFO ? 32'h1 : 32'h3, "ovf_cleared");
      rd(2'd1, 32'h09, "ovf_buttons");

      // Bridge never ready: timeout, BUTTONS kept, polling resumes.
      cfg_stuck = 1;
      t0 = m_tos; n = 0;
      wr(2'd3, 32'h1);
      while (m_tos == t0 && n < 300) begin tick(); n++; end
      if (m_tos == t0) expired("timeout_wait");
      cfg_stuck = 0; cfg_joy = 8'h77; cfg_lat = 4;
      rd(2'd0, 32'h9, "to_status");
      rd(2'd1, 32'h09, "to_buttons");
      t0 = m_polls; n = 0;
      while (m_polls == t0 && n < 200) begin tick(); n++; end
      if (m_polls == t0) expired("resume_wait");
      wr(2'd3, 32'h0);
      rd(2'd1, 32'h77, "resume_buttons");
      wr(2'd0, 32'h8);
      rd(2'd0, FIFO ? 32'h3 : 32'h1, "to_cleared");
      rd(2'd2, FIFO ? 32'h0001_7608 : 32'h0, "resume_event");

      // Reset during S_WAIT.
      cfg_stuck = 1;
      wr(2'd3, 32'h3);
      n = 0;
      while (!(m_busy && m_t >= 3) && n < 100) begin tick(); n++; end
      if (!(m_busy && m_t >= 3)) expired("wait_state");
      rst = 1'b1; tick(); rst = 1'b0;
      rd(2'd0, 32'h0, "wrst_status");
      rd(2'd1, 32'h0, "wrst_buttons");
      rd(2'd3, 32'h0, "wrst_ctrl");
      repeat (40) tick();
      cfg_stuck = 0; cfg_joy = 8'h42;
      run_poll();
      rd(2'd1, 32'h42, "wrst_resume");

      // Randomized traffic.
      wr(2'd3, 32'h3);
      for (int c = 0; c < 4000; c++) begin
         int r;
         r = int'($urandom_range(0, 99));
         bus_if.bus_we = 1'b0; bus_if.bus_re = 1'b0;
         bus_if.bus_addr = 2'($urandom_range(0, 3));
         if (r < 10) begin
            bus_if.bus_we = 1'b1;
            if (bus_if.bus_addr == 2'd3)
               bus_if.bus_wdata = {30'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) != 0)};
            else
               bus_if.bus_wdata = $urandom;
         end else if (r < 40) begin
            bus_if.bus_re = 1'b1;
         end
         if ($urandom_range(0, 19) == 0) begin
            cfg_joy   = 8'($urandom);
            cfg_lat   = int'($urandom_range(2, 10));
            cfg_good  = ($urandom_range(0, 9) != 0);
            cfg_stuck = ($urandom_range(0, 19) == 0);
         end
         rst = ($urandom_range(0, 999) == 0);
         tick();
      end
      bus_if.bus_we = 1'b0; bus_if.bus_re = 1'b0; rst = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/joypad_poller.md
# joypad_poller

Upstream sequencer and CPU-facing register file for `nes_bridge`. Periodically issues `start` to the bridge, waits for the transaction to finish and reads back the 8-bit joypad byte through the bridge's `rdata_addr`/`rdata` port. It then derives press/release edges and queues them as events with an optional interrupt. It sits between the MMIO bus decoder and `nes_bridge`.

## Interface
- `POLL_CYCLES`, 1_000_000: clocks between poll starts (50 Hz at 50 MHz); must be ≥ 4.
- `TIMEOUT_CYCLES`, 4_000_000: maximum clocks spent waiting for bridge `ready` before abort.
- `FIFO_DEPTH`, 8: event FIFO entries; power of two, ≥ 2.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `bus_addr` in 2: word select; 0 STATUS, 1 BUTTONS, 2 EVENT, 3 CTRL.
- `bus_we` in 1: write strobe, single cycle.
- `bus_re` in 1: read strobe, single cycle.
- `bus_wdata` in 32: write data.
- `bus_rdata` out 32: read data, combinational from `bus_addr`.
- `irq` out 1: level interrupt.
- `br_start` out 1: one-cycle start pulse to `nes_bridge`.
- `br_addr` out 2: `nes_bridge` `rdata_addr`.
- `br_rdata` in 8: `nes_bridge` `rdata`, combinational on `br_addr`.

## Operation
- **Registers**
  - CTRL: bit0 `en`, bit1 `irq_en`. Read/write. Reset 0.
  - STATUS (RO): bit0 `valid`, meaning at least one good poll has completed. bit1 `ev_nonempty`. bit2 `overflow`, sticky. bit3 `timeout`, sticky.
  - Writing STATUS with bit2 or bit3 set clears the corresponding sticky bit.
  - BUTTONS (RO): bits[7:0] hold the last good joypad byte.
  - EVENT: reading returns `{15'b0, valid_entry, pressed[7:0], released[7:0]}` and pops one entry if non-empty. Reading while empty returns 0 and pops nothing. Writes are ignored.
- **FSM**
  - `S_IDLE`: poll counter runs only while `en`=1. On reaching `POLL_CYCLES-1`, go to `S_KICK` and clear the counter.
  - `S_KICK`: `br_start`=1 for exactly one cycle, `br_addr`=00. Go to `S_GAP`.
  - `S_GAP`: wait one cycle; the bridge drops `ready` one cycle after start. Go to `S_WAIT`.
  - `S_WAIT`: `br_addr`=00. If `br_rdata[0]`=1, go to `S_CHECK`. If the timeout counter reaches `TIMEOUT_CYCLES-1`, set `timeout` and go to `S_IDLE`.
  - `S_CHECK`: `br_addr`=01. If bit0=1, go to `S_READ`. Otherwise the poll is discarded, `timeout` is set, and the FSM returns to `S_IDLE`.
  - `S_READ`: `br_addr`=10. Sample `br_rdata` as `new`. Compute `pressed = new & ~BUTTONS` and `released = ~new & BUTTONS`. Update BUTTONS and set `valid`. If `pressed|released` ≠ 0, push an event. Return to `S_IDLE`.
- `br_addr`=00 in every state not listed above.
- Clearing `en` mid-transaction does not abort it. The in-flight poll completes; the next poll is not scheduled.
- The first good poll compares against BUTTONS=0, so it reports every held button as pressed.
- **FIFO**
  - Push while full: the entry is dropped and `overflow` is set.
  - Push and pop in the same cycle while full: the pop is taken first and the push succeeds; `overflow` is not set.
  - Push and pop in the same cycle while empty: the pop returns 0 and the push succeeds.
- `irq = irq_en & ev_nonempty`.

## Timing
- After reset:
  - All registers 0; FIFO empty; FSM in `S_IDLE`.
  - `irq`=0, `br_start`=0, `br_addr`=00.
- Reset asserted mid-transaction returns the FSM to `S_IDLE` the next cycle. The bridge is not reset by this block.
- First `br_start` occurs `POLL_CYCLES` clocks after `en` is set.
- Start-to-start period is at least `POLL_CYCLES`. The poll counter holds while the FSM is out of `S_IDLE`.
- `S_CHECK` and `S_READ` take one cycle each.
- BUTTONS and the FIFO update on the clock edge ending `S_READ`. `irq` rises on the following cycle.
- EVENT pop takes effect on the clock edge of the `bus_re` cycle. `bus_rdata` shows the head entry during that cycle.

## Configuration
- `JOYPAD_EVENT_FIFO_EN` defined: event FIFO, EVENT register, `overflow` and `ev_nonempty` behave as above.
- Not defined:
  - No FIFO is built. EVENT reads 0.
  - STATUS bit1 becomes a sticky `changed` flag. It is set when `pressed|released` ≠ 0 and cleared by any read of BUTTONS.
  - STATUS bit2 reads 0.
  - `irq = irq_en & changed`.

## Test plan
- `en`=1, `POLL_CYCLES`=16, bridge model returns joypad 0x81. After the first poll: BUTTONS=0x81, `valid`=1, and EVENT returns 0x0001_8100. A second EVENT read returns 0.
- Joypad sequence 0x81 → 0x03: the second event is 0x0001_0280 (pressed 0x02, released 0x80).
- Identical consecutive bytes 0x55, 0x55: only one event is queued, and no event is queued on the second poll.
- Nine distinct changes with no pops at `FIFO_DEPTH`=8: 8 entries retained and `overflow`=1. A STATUS write of 0x4 clears it.
- Bridge `ready` held at 0 with `TIMEOUT_CYCLES`=32: `timeout`=1 and BUTTONS unchanged. Polling resumes at the next period.
- `rst` pulsed during `S_WAIT`: all outputs return to reset values, then resume with `br_start` pulsing only after `en` is written again.
